// File: rtl/config_pkg.sv
// config_pkg
// Shared definitions for the configuration edit controller:
//   - group encodings (which RTC register group is being edited)
//   - FSM state encoding
//   - per-group, per-field inclusive BCD limits and lookup helpers
// No ports; imported by config_edit_ctrl.
package config_pkg;

    localparam logic [1:0] GRP_HORA  = 2'd0;
    localparam logic [1:0] GRP_FECHA = 2'd1;
    localparam logic [1:0] GRP_TIMER = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Inclusive BCD limits. Timer shares the hora limits.
    localparam logic [7:0] HH_MIN   = 8'h00;
    localparam logic [7:0] HH_MAX   = 8'h23;
    localparam logic [7:0] MS_MIN   = 8'h00;
    localparam logic [7:0] MS_MAX   = 8'h59;
    localparam logic [7:0] DAY_MIN  = 8'h01;
    localparam logic [7:0] DAY_MAX  = 8'h31;
    localparam logic [7:0] MES_MIN  = 8'h01;
    localparam logic [7:0] MES_MAX  = 8'h12;
    localparam logic [7:0] YEAR_MIN = 8'h00;
    localparam logic [7:0] YEAR_MAX = 8'h99;

    // Field index: 0 = left, 1 = middle, 2 = right.
    function automatic logic [7:0] field_min(input logic [1:0] grp, input logic [1:0] idx);
        logic [7:0] m;
        m = 8'h00;
        if (grp == GRP_FECHA) begin
            case (idx)
                2'd0:    m = DAY_MIN;
                2'd1:    m = MES_MIN;
                default: m = YEAR_MIN;
            endcase
        end else begin
            case (idx)
                2'd0:    m = HH_MIN;
                default: m = MS_MIN;
            endcase
        end
        return m;
    endfunction

    function automatic logic [7:0] field_max(input logic [1:0] grp, input logic [1:0] idx);
        logic [7:0] m;
        m = 8'h00;
        if (grp == GRP_FECHA) begin
            case (idx)
                2'd0:    m = DAY_MAX;
                2'd1:    m = MES_MAX;
                default: m = YEAR_MAX;
            endcase
        end else begin
            case (idx)
                2'd0:    m = HH_MAX;
                default: m = MS_MAX;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/bcd_field_step.sv
// bcd_field_step
// Combinational one-step BCD increment/decrement of a single 2-digit field
// with wrap-around at inclusive limits.
// Ports:
//   value    in  8  current packed BCD {tens,units}
//   min_val  in  8  inclusive lower limit (BCD)
//   max_val  in  8  inclusive upper limit (BCD)
//   inc      in  1  step up
//   dec      in  1  step down
//   next_val out 8  stepped value (value unchanged when neither or both steps)
// A value outside [min,max] or with a non-decimal nibble is treated as
// unusable: incrementing lands on min, decrementing lands on max.
module bcd_field_step (
    input  logic [7:0] value,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] next_val
);

    logic [3:0] hi;
    logic [3:0] lo;
    logic       valid;

    assign hi    = value[7:4];
    assign lo    = value[3:0];
    // Plain binary comparison is order-preserving for well-formed BCD.
    assign valid = (hi <= 4'd9) && (lo <= 4'd9) && (value >= min_val) && (value <= max_val);

    always_comb begin
        next_val = value;
        if (inc && !dec) begin
            if (!valid || value == max_val)
                next_val = min_val;
            else if (lo == 4'd9)
                next_val = {hi + 4'd1, 4'd0};
            else
                next_val = {hi, lo + 4'd1};
        end else if (dec && !inc) begin
            if (!valid || value == min_val)
                next_val = max_val;
            else if (lo == 4'd0)
                next_val = {hi - 4'd1, 4'd9};
            else
                next_val = {hi, lo - 4'd1};
        end
    end

endmodule

// File: rtl/config_edit_ctrl.sv
// config_edit_ctrl
// Pushbutton-driven configuration controller feeding the VGA clock screen
// and the RTC write path.
// Ports:
//   clock, reset                 system clock, async active-low reset
//   sw_hora/sw_fecha/sw_timer    group-select switch levels (debounced)
//   btn_up/down/left/right       button levels (debounced)
//   cur_hora/cur_fecha/cur_timer current BCD values {f0,f1,f2}
//   write_ack                    RTC writer accepted the data
//   config_mode                  high while editing
//   cursor_location              selected field 0..2
//   edit_f0/f1/f2                edit-buffer BCD fields
//   edit_group                   0 hora, 1 fecha, 2 timer
//   write_req                    commit request, held until write_ack
// All inputs go through one register stage of edge detection, so an input
// edge shows on the outputs two clock edges later.
module config_edit_ctrl
    import config_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sw_hora,
    input  logic        sw_fecha,
    input  logic        sw_timer,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic [23:0] cur_hora,
    input  logic [23:0] cur_fecha,
    input  logic [23:0] cur_timer,
    input  logic        write_ack,
    output logic        config_mode,
    output logic [1:0]  cursor_location,
    output logic [7:0]  edit_f0,
    output logic [7:0]  edit_f1,
    output logic [7:0]  edit_f2,
    output logic [1:0]  edit_group,
    output logic        write_req
);

    localparam logic [31:0] REP_FIRST = 32'(REPEAT_DELAY);
    localparam logic [31:0] REP_LAST  = 32'(REPEAT_DELAY + REPEAT_PERIOD);

    state_t      state;

    // Edge-detect history and registered edge events.
    logic        armed;
    logic [2:0]  sw_prev;
    logic        up_prev, down_prev, left_prev, right_prev;
    logic [2:0]  sw_rise_r, sw_fall_r;
    logic        inc_r, dec_r, left_r, right_r;
    logic [31:0] rep_cnt;

    logic [2:0]  sw;
    logic [2:0]  sw_rise, sw_fall;
    logic        held;
    logic        rep_hit;
    logic        left_rise, right_rise;

    assign sw = {sw_timer, sw_fecha, sw_hora};
    // armed masks the first cycle after reset so a switch already high at
    // release is taken as the starting level, not as an edge.
    assign sw_rise    = sw & ~sw_prev & {3{armed}};
    assign sw_fall    = ~sw & sw_prev & {3{armed}};
    assign held       = btn_up ^ btn_down;
    // Repeat hits at DELAY, then every PERIOD (counter wraps LAST -> FIRST+1).
    assign rep_hit    = held && (rep_cnt == REP_FIRST || rep_cnt == REP_LAST);
    assign left_rise  = btn_left & ~left_prev;
    assign right_rise = btn_right & ~right_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armed      <= 1'b0;
            sw_prev    <= 3'b000;
            up_prev    <= 1'b0;
            down_prev  <= 1'b0;
            left_prev  <= 1'b0;
            right_prev <= 1'b0;
            sw_rise_r  <= 3'b000;
            sw_fall_r  <= 3'b000;
            inc_r      <= 1'b0;
            dec_r      <= 1'b0;
            left_r     <= 1'b0;
            right_r    <= 1'b0;
            rep_cnt    <= 32'd0;
        end else begin
            armed      <= 1'b1;
            sw_prev    <= sw;
            up_prev    <= btn_up;
            down_prev  <= btn_down;
            left_prev  <= btn_left;
            right_prev <= btn_right;
            sw_rise_r  <= sw_rise;
            sw_fall_r  <= sw_fall;
            // Opposing buttons cancel: a step needs exactly one of up/down.
            inc_r      <= btn_up & ~btn_down & (~up_prev | rep_hit);
            dec_r      <= btn_down & ~btn_up & (~down_prev | rep_hit);
            left_r     <= left_rise & ~right_rise;
            right_r    <= right_rise & ~left_rise;
            if (!held || state != ST_EDIT)
                rep_cnt <= 32'd0;
            else if (rep_cnt == REP_LAST)
                rep_cnt <= REP_FIRST + 32'd1;
            else
                rep_cnt <= rep_cnt + 32'd1;
        end
    end

    // Group selection on entry: hora > fecha > timer.
    logic [1:0]  load_group;
    logic [23:0] load_bus;

    always_comb begin
        load_group = GRP_TIMER;
        load_bus   = cur_timer;
        if (sw_rise_r[0]) begin
            load_group = GRP_HORA;
            load_bus   = cur_hora;
        end else if (sw_rise_r[1]) begin
            load_group = GRP_FECHA;
            load_bus   = cur_fecha;
        end
    end

    // Falling edge of the switch that opened this edit session.
    logic sel_fall;

    always_comb begin
        case (edit_group)
            GRP_HORA:  sel_fall = sw_fall_r[0];
            GRP_FECHA: sel_fall = sw_fall_r[1];
            GRP_TIMER: sel_fall = sw_fall_r[2];
            default:   sel_fall = 1'b0;
        endcase
    end

    // Single shared stepper, fed with the field under the cursor.
    logic [7:0] field_val;
    logic [7:0] step_val;

    always_comb begin
        case (cursor_location)
            2'd0:    field_val = edit_f0;
            2'd1:    field_val = edit_f1;
            default: field_val = edit_f2;
        endcase
    end

    bcd_field_step u_step (
        .value    (field_val),
        .min_val  (field_min(edit_group, cursor_location)),
        .max_val  (field_max(edit_group, cursor_location)),
        .inc      (inc_r),
        .dec      (dec_r),
        .next_val (step_val)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            config_mode     <= 1'b0;
            cursor_location <= 2'd0;
            edit_f0         <= 8'h00;
            edit_f1         <= 8'h00;
            edit_f2         <= 8'h00;
            edit_group      <= 2'd0;
            write_req       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|sw_rise_r) begin
                        edit_f0         <= load_bus[23:16];
                        edit_f1         <= load_bus[15:8];
                        edit_f2         <= load_bus[7:0];
                        edit_group      <= load_group;
                        cursor_location <= 2'd0;
                        config_mode     <= 1'b1;
                        state           <= ST_EDIT;
                    end
                end
                ST_EDIT: begin
                    // Exit wins over any button event registered alongside it.
                    if (sel_fall) begin
                        config_mode <= 1'b0;
                        write_req   <= 1'b1;
                        state       <= ST_COMMIT;
                    end else begin
                        if (inc_r || dec_r) begin
                            case (cursor_location)
                                2'd0:    edit_f0 <= step_val;
                                2'd1:    edit_f1 <= step_val;
                                default: edit_f2 <= step_val;
                            endcase
                        end
                        if (right_r) begin
                            cursor_location <= (cursor_location == 2'd2) ? 2'd0
                                                                         : cursor_location + 2'd1;
                        end else if (left_r) begin
                            cursor_location <= (cursor_location == 2'd0) ? 2'd2
                                                                         : cursor_location - 2'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (write_ack) begin
                        write_req <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
